// File: rtl/fifo_ctl_pkg.sv
// Shared types and defaults for the FIFO round-robin controller.
package fifo_ctl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_GAP
    } rd_state_t;

    localparam int BURST_DEF = 4;
    localparam int TMO_DEF   = 15;

endpackage

// File: rtl/fifo_rr_ctl_if.sv
// Requester, FIFO-side and consumer signals of the controller.
interface fifo_rr_ctl_if #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int ADDRBIT = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] reqdat;
    logic [NREQ-1:0]       gnt;
    logic                  fifowr;
    logic [WIDTH-1:0]      fifodin;
    logic [ADDRBIT:0]      fifolen;
    logic                  notempty;
    logic [WIDTH-1:0]      fifodout;
    logic                  fiford;
    logic                  sink_rdy;
    logic [WIDTH-1:0]      odat;
    logic                  ovld;
    logic                  osop;
    logic                  oeop;

    modport master (
        input  req, reqdat, fifolen, notempty,
        input  fifodout, sink_rdy,
        output gnt, fifowr, fifodin, fiford,
        output odat, ovld, osop, oeop
    );

    modport slave (
        output req, reqdat, fifolen, notempty,
        output fifodout, sink_rdy,
        input  gnt, fifowr, fifodin, fiford,
        input  odat, ovld, osop, oeop
    );
endinterface

// File: rtl/fifo_rr_ctl_rr_pick.sv
// Circular priority encoder: first set req bit at or after rrptr.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rrptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);
    always_comb begin : pick
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rrptr) + k) % NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end
endmodule

// File: rtl/fifo_rr_ctl.sv
// Round-robin FIFO write arbiter and framed burst read sequencer.
module fifo_rr_ctl
    import fifo_ctl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int ADDRBIT = 4,
    parameter int BURST   = BURST_DEF,
    parameter int TMO     = TMO_DEF
) (
    input logic clk,
    input logic rst,
    fifo_rr_ctl_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW = ADDRBIT + 1;
    localparam logic [LW:0]   DEPTH   = (LW+1)'(2**ADDRBIT);
    localparam logic [LW-1:0] BURST_L = LW'(BURST);
    localparam logic [7:0]    TMO_L   = 8'(TMO);

    logic [PW-1:0]   rrptr;
    logic [PW-1:0]   gidx;
    logic [NREQ-1:0] pick;
    logic            room;
    logic            rd;
    rd_state_t       state;
    logic [7:0]      timer;
    logic [LW-1:0]   cnt;
    logic [LW-1:0]   target;

    // the registered write still in flight already owns a slot
    assign room = ({1'b0, bus.fifolen}
                 + {{LW{1'b0}}, bus.fifowr}) < DEPTH;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (bus.req),
        .rrptr (rrptr),
        .gnt   (pick),
        .idx   (gidx)
    );

    assign bus.gnt = (room && !rst) ? pick : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fifowr  <= 1'b0;
            bus.fifodin <= '0;
            rrptr       <= '0;
        end else if (|bus.gnt) begin
            bus.fifowr  <= 1'b1;
            bus.fifodin <= bus.reqdat[gidx*WIDTH +: WIDTH];
            rrptr       <= (gidx == PW'(NREQ-1))
                         ? '0 : gidx + PW'(1);
        end else begin
            bus.fifowr  <= 1'b0;
        end
    end

    assign rd = (state == S_RD) && bus.sink_rdy
              && bus.notempty;
    assign bus.fiford = rd;
    assign bus.ovld   = rd;
    assign bus.odat   = bus.fifodout;
    assign bus.osop   = rd && (cnt == '0);
    assign bus.oeop   = rd && (cnt == target - LW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            timer  <= '0;
            cnt    <= '0;
            target <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.fifolen >= BURST_L) begin
                        state  <= S_RD;
                        target <= BURST_L;
                        timer  <= '0;
                    end else if (timer == TMO_L
                                 && bus.notempty) begin
                        state  <= S_RD;
                        target <= bus.fifolen;
                        timer  <= '0;
                    end else if (bus.notempty) begin
                        if (timer != TMO_L)
                            timer <= timer + 8'd1;
                    end else begin
                        timer <= '0;
                    end
                end
                S_RD: begin
                    if (rd) begin
                        if (cnt == target - LW'(1)) begin
                            state <= S_GAP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + LW'(1);
                        end
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/fifo_rr_ctl.md
# fifo_rr_ctl

Round-robin write arbiter and burst read sequencer for the shared register FIFO (show-ahead, `fifolen`/`fifofull`/`notempty` status). It admits up to NREQ producers into one FIFO without overflow. It drains the FIFO to a single consumer in framed bursts of BURST words, or in a shorter burst after an idle timeout. The block sits between the requester bus and the FIFO instance and owns both the FIFO's `fifowr` and `fiford` pins.

## Interface
Parameters:
- NREQ, 4, number of write requesters (2..8)
- WIDTH, 8, data width
- ADDRBIT, 4, FIFO address bits; FIFO depth = 2^ADDRBIT
- BURST, 4, words per full read burst (1..2^ADDRBIT)
- TMO, 15, idle cycles before a partial burst is forced (1..255)

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- req  in  NREQ  per-requester write request; held until granted
- reqdat  in  NREQ*WIDTH  requester data; slice i is bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, combinational, same cycle as req
- fifowr  out  1  registered FIFO write strobe
- fifodin  out  WIDTH  registered FIFO write data
- fifolen  in  ADDRBIT+1  FIFO occupancy
- notempty  in  1  FIFO not empty
- fifodout  in  WIDTH  FIFO head word
- fiford  out  1  FIFO read strobe, combinational
- sink_rdy  in  1  consumer ready
- odat  out  WIDTH  output word (= fifodout)
- ovld  out  1  output valid (= fiford)
- osop  out  1  first word of burst
- oeop  out  1  last word of burst

## Operation
- Write admission: `room = (fifolen + fifowr) < 2^ADDRBIT`. The in-flight registered write counts against occupancy.
- Arbitration: when `room`, grant the lowest set bit of req at or after rrptr, searching circularly. `gnt` is all-zero when `!room` or when req = 0.
- On a grant to i: fifodin <= reqdat[i] and fifowr <= 1 at the next edge, rrptr <= (i+1) mod NREQ. Otherwise fifowr <= 0, and rrptr holds.
- Read FSM:
  - IDLE: timer increments while `notempty && fifolen < BURST`, saturating at TMO. It clears when the FIFO is empty or when leaving IDLE. Go to RD when `fifolen >= BURST`; target = BURST. Otherwise go to RD when `timer == TMO`; target = fifolen (partial burst).
  - RD: `fiford = sink_rdy && notempty`. A word counter (ADDRBIT+1 bits) increments per read. osop is on the read with count 0. oeop is on the read where count == target-1; that read moves the FSM to GAP.
  - GAP: one idle cycle, then go to IDLE.
- fiford is never asserted outside RD and never asserted when notempty = 0.
- Simultaneous FIFO read and write in one cycle is legal; the FIFO nets the length change.

## Timing
- Reset values: gnt = 0, fifowr = 0, fifodin = 0, fiford/ovld/osop/oeop = 0, rrptr = 0, FSM = IDLE, timer = 0, counter = 0.
- Write latency: a request granted in cycle n writes the FIFO at the edge ending cycle n+1. fifolen reflects the write in cycle n+2.
- Back-to-back grants, one per cycle, are allowed while room holds.
- At full boundary: fifolen = 2^ADDRBIT-1 with fifowr = 1 gives room = 0, so no grant that cycle.
- Read: odat/ovld/osop/oeop are valid in the same cycle as fiford, because the FIFO is show-ahead.
- Sink stall in RD: the FSM holds and the counter holds. The burst resumes without re-issuing osop.
- Partial burst: target is latched at IDLE→RD. Writes arriving during RD do not extend the burst.
- Reset asserted mid-burst: all state returns to reset values immediately; FIFO contents are the FIFO's concern.

## Structure
- Shared package `fifo_ctl_pkg`: FSM state encoding (IDLE/RD/GAP) and the default BURST/TMO constants.
- One natural sub-module: `rr_pick`, a combinational circular priority encoder taking NREQ, req, and rrptr and producing a one-hot grant and its index.
- The FIFO itself is instantiated by the parent, not inside this block.

## Test plan
- Reset with all req = 1 → gnt = 0 and fifowr = 0 during reset. In the first cycle after reset, gnt = 4'b0001; then 0010, 0100, 1000, 0001 on successive cycles.
- ADDRBIT = 4, hold req = 4'b0101 until the FIFO fills → exactly 16 writes occur, fifolen never exceeds 16, and gnt = 0 once fifolen + fifowr reaches 16.
- Write 4 words with BURST = 4 and sink_rdy = 1 → 4 consecutive ovld cycles, osop on word 0, oeop on word 3, one GAP cycle, data in write order.
- Write 2 words and keep sink_rdy = 1 → after TMO = 15 idle cycles, a 2-word burst with osop on word 0 and oeop on word 1.
- Drop sink_rdy for 3 cycles after word 1 of a burst → ovld = 0 for those cycles, no second osop, oeop on word 3.
- Assert rst during the word-2 read → all outputs return to 0 asynchronously and the FSM is in IDLE on release.
